// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: datapath word width and the encodings used by
// the EX->MEM forwarding select and the writeback source select.
package cpu_pkg;

  localparam int WORD_W = 32;

  // Forwarding / writeback source selector encodings (index into in_data)
  typedef enum logic [1:0] {
    SEL_REG   = 2'd0,
    SEL_EXMEM = 2'd1,
    SEL_MEMWB = 2'd2,
    SEL_IMM   = 2'd3
  } fwd_sel_e;

endpackage : cpu_pkg

// File: rtl/pipe_skid_buf.sv
// Two-entry registered output stage (main + skid) with valid/ready handshake
// and flush. in_ready comes straight from the skid occupancy flop, so it never
// has a combinational path from out_ready.
module pipe_skid_buf #(
  parameter int BEAT_W = 33
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BEAT_W-1:0] in_beat,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic [BEAT_W-1:0] out_beat,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [BEAT_W-1:0] main_q, main_d;
  logic [BEAT_W-1:0] skid_q, skid_d;
  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic              xfer_in_s;
  logic              xfer_out_s;

  assign in_ready   = ~skid_valid_q;
  assign xfer_in_s  = in_valid & ~skid_valid_q;
  assign xfer_out_s = main_valid_q & out_ready;
  assign out_beat   = main_q;
  assign out_valid  = main_valid_q;

  // Next-state for main and skid registers, highest-priority event first
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      // Drop everything buffered and any beat offered this cycle; data is held
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q && xfer_out_s) begin
      // Drain skid into main; in_ready was low so nothing new arrives
      main_d       = skid_q;
      skid_valid_d = 1'b0;
    end else if (xfer_in_s && (!main_valid_q || out_ready)) begin
      main_d       = in_beat;
      main_valid_d = 1'b1;
    end else if (xfer_in_s) begin
      // Main is occupied and stalled: park the beat in the skid slot
      skid_d       = in_beat;
      skid_valid_d = 1'b1;
    end else if (xfer_out_s) begin
      main_valid_d = 1'b0;
    end else begin
      main_valid_d = main_valid_q;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_q       <= {BEAT_W{1'b0}};
      skid_q       <= {BEAT_W{1'b0}};
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

endmodule : pipe_skid_buf

// File: rtl/pipe_sel_mux.sv
// NUM_IN:1 datapath select feeding a back-pressurable registered output stage.
// An out-of-range select (only possible for non-power-of-2 NUM_IN) produces a
// zero data word flagged with out_err; the flag travels with its beat.
module pipe_sel_mux
  import cpu_pkg::*;
#(
  parameter  int WIDTH  = WORD_W,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [WIDTH-1:0] sel_data_s;
  logic             sel_err_s;
  logic [WIDTH:0]   out_beat_s;

  // Pick input[in_sel]; a select matching no input leaves data zero and err set
  always_comb begin
    sel_data_s = {WIDTH{1'b0}};
    sel_err_s  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (int'(in_sel) == k) begin
        sel_data_s = in_data[k*WIDTH +: WIDTH];
        sel_err_s  = 1'b0;
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

  pipe_skid_buf #(
    .BEAT_W (WIDTH + 1)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_beat   ({sel_err_s, sel_data_s}),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_beat  (out_beat_s),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign out_err  = out_beat_s[WIDTH];
  assign out_data = out_beat_s[WIDTH-1:0];

endmodule : pipe_sel_mux

// File: tb/tb_pipe_sel_mux.sv
// Self-checking bench for pipe_sel_mux: directed scenarios plus a randomized
// run scored against a queue-based model of a 2-deep FIFO output stage.
module tb_pipe_sel_mux;

  logic         clk;
  logic         reset;

  // NUM_IN=4 instance
  logic [127:0] in_data;
  logic [1:0]   in_sel;
  logic         in_valid;
  logic         in_ready;
  logic         flush;
  logic [31:0]  out_data;
  logic         out_err;
  logic         out_valid;
  logic         out_ready;

  // NUM_IN=3 instance
  logic [95:0]  in_data3;
  logic [1:0]   in_sel3;
  logic         in_valid3;
  logic         in_ready3;
  logic         flush3;
  logic [31:0]  out_data3;
  logic         out_err3;
  logic         out_valid3;
  logic         out_ready3;

  int errors = 0;
  int checks = 0;

  // Reference model: FIFO of {err,data} beats, capacity 2, plus last shown word
  logic [32:0]  mq[$];
  logic [32:0]  m_last;

  pipe_sel_mux #(.WIDTH(32), .NUM_IN(4)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .out_data(out_data), .out_err(out_err), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  pipe_sel_mux #(.WIDTH(32), .NUM_IN(3)) dut3 (
    .clk(clk), .reset(reset), .in_data(in_data3), .in_sel(in_sel3),
    .in_valid(in_valid3), .in_ready(in_ready3), .flush(flush3),
    .out_data(out_data3), .out_err(out_err3), .out_valid(out_valid3),
    .out_ready(out_ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge, updating the model from the inputs currently driven
  task automatic step();
    logic [32:0] beat;
    bit          push_ok;
    beat    = {1'b0, in_data[in_sel*32 +: 32]};
    push_ok = in_valid && (mq.size() < 2);
    if (flush) begin
      mq.delete();
    end else begin
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (push_ok) mq.push_back(beat);
    end
    if (mq.size() > 0) m_last = mq[0];
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mq.delete();
    m_last = 33'd0;
  endtask

  task automatic test_reset();
    in_valid = 1'b0; in_sel = 2'd0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    in_valid3 = 1'b0; in_sel3 = 2'd0; in_data3 = '0; flush3 = 1'b0; out_ready3 = 1'b1;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'd0 || out_err !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=%h err=%b in_ready=%b, want 0/0/0/1",
               out_valid, out_data, out_err, in_ready);
    end
    // Fill main and skid, then reset without a clock edge
    in_data = {4{32'h0000_00F1}}; in_valid = 1'b1; step();
    in_data = {4{32'h0000_00F2}}; step();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'hF1) begin
      errors++;
      $display("FAIL reset_prefill: in_ready=%b valid=%b data=%h, want 0/1/f1",
               in_ready, out_valid, out_data);
    end
    #1 reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'd0 || out_err !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_async: valid=%b data=%h err=%b in_ready=%b, want 0/0/0/1",
               out_valid, out_data, out_err, in_ready);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_reappear: valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_streaming();
    logic [31:0] exp_s [4];
    exp_s[0] = 32'hA; exp_s[1] = 32'hB; exp_s[2] = 32'hC; exp_s[3] = 32'hD;
    in_data = {32'hD, 32'hC, 32'hB, 32'hA};
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_sel = 2'(i);
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_s[i] || out_err !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_%0d: valid=%b data=%h err=%b in_ready=%b, want 1/%h/0/1",
                 i, out_valid, out_data, out_err, in_ready, exp_s[i]);
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'hD) begin
      errors++;
      $display("FAIL stream_drain: valid=%b data=%h, want 0/d", out_valid, out_data);
    end
  endtask

  task automatic test_back_pressure();
    logic [31:0] exp_d [6];
    logic        exp_v [6];
    logic        exp_r [6];
    logic [31:0] drv   [6];
    logic        drv_v [6];
    logic        drv_or[6];
    // cycle-by-cycle table: driven beat/valid/out_ready and expected outputs
    drv[0]=32'h11; drv_v[0]=1; drv_or[0]=0; exp_d[0]=32'h11; exp_v[0]=1; exp_r[0]=1;
    drv[1]=32'h22; drv_v[1]=1; drv_or[1]=0; exp_d[1]=32'h11; exp_v[1]=1; exp_r[1]=0;
    drv[2]=32'h33; drv_v[2]=1; drv_or[2]=0; exp_d[2]=32'h11; exp_v[2]=1; exp_r[2]=0;
    drv[3]=32'h33; drv_v[3]=1; drv_or[3]=1; exp_d[3]=32'h22; exp_v[3]=1; exp_r[3]=1;
    drv[4]=32'h33; drv_v[4]=1; drv_or[4]=1; exp_d[4]=32'h33; exp_v[4]=1; exp_r[4]=1;
    drv[5]=32'h44; drv_v[5]=0; drv_or[5]=1; exp_d[5]=32'h33; exp_v[5]=0; exp_r[5]=1;
    in_sel = 2'd2;
    for (int i = 0; i < 6; i++) begin
      in_data = {4{drv[i]}};
      in_valid = drv_v[i];
      out_ready = drv_or[i];
      step();
      checks++;
      if (out_valid !== exp_v[i] || out_data !== exp_d[i] || in_ready !== exp_r[i]) begin
        errors++;
        $display("FAIL backpressure_%0d: valid=%b data=%h in_ready=%b, want %b/%h/%b",
                 i, out_valid, out_data, in_ready, exp_v[i], exp_d[i], exp_r[i]);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_flush();
    in_sel = 2'd1;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = {4{32'h44}}; step();
    in_data = {4{32'h55}}; step();
    // Full buffer plus an offered beat, all flushed
    in_data = {4{32'h66}}; flush = 1'b1; step();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h44) begin
      errors++;
      $display("FAIL flush_full: valid=%b in_ready=%b data=%h, want 0/1/44",
               out_valid, in_ready, out_data);
    end
    in_valid = 1'b0; out_ready = 1'b1; step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_reappear: valid=%b want 0", out_valid);
    end
    // One beat held, flush races with an accepted-looking beat
    in_valid = 1'b1; out_ready = 1'b0; in_data = {4{32'h77}}; step();
    in_data = {4{32'h88}}; flush = 1'b1; step();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h77) begin
      errors++;
      $display("FAIL flush_drop_in: valid=%b data=%h, want 0/77", out_valid, out_data);
    end
    out_ready = 1'b1; step();
  endtask

  task automatic test_out_of_range();
    in_data3 = {32'h3C, 32'h3B, 32'h3A};
    out_ready3 = 1'b1;
    in_valid3 = 1'b1;
    in_sel3 = 2'd3;
    step();
    checks++;
    if (out_valid3 !== 1'b1 || out_data3 !== 32'd0 || out_err3 !== 1'b1) begin
      errors++;
      $display("FAIL sel_oor: valid=%b data=%h err=%b, want 1/0/1", out_valid3, out_data3, out_err3);
    end
    in_sel3 = 2'd1;
    step();
    checks++;
    if (out_valid3 !== 1'b1 || out_data3 !== 32'h3B || out_err3 !== 1'b0) begin
      errors++;
      $display("FAIL sel_after_oor: valid=%b data=%h err=%b, want 1/3b/0", out_valid3, out_data3, out_err3);
    end
    in_sel3 = 2'd2;
    step();
    checks++;
    if (out_data3 !== 32'h3C || out_err3 !== 1'b0) begin
      errors++;
      $display("FAIL sel3_in2: data=%h err=%b, want 3c/0", out_data3, out_err3);
    end
    in_valid3 = 1'b0;
    step();
  endtask

  task automatic test_random();
    int bad = 0;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_sel    = 2'($urandom_range(0, 3));
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 63) == 0);
      checks++;
      if (in_ready !== (mq.size() < 2)) begin
        errors++;
        if (bad++ < 10) $display("FAIL rand_in_ready cyc %0d: got %b want %b", c, in_ready, mq.size() < 2);
      end
      step();
      checks++;
      if (out_valid !== (mq.size() > 0) || out_data !== m_last[31:0] || out_err !== m_last[32]) begin
        errors++;
        if (bad++ < 10)
          $display("FAIL rand_out cyc %0d: valid=%b data=%h err=%b, want %b/%h/%b",
                   c, out_valid, out_data, out_err, mq.size() > 0, m_last[31:0], m_last[32]);
      end
    end
    in_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_out_of_range();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_pipe_sel_mux
